// File: rtl/vticket_scheduler.sv
// Vector ticket issue controller: tracks in-flight tickets in a pending bitmap,
// throttles issue at the in-flight limit and drains before admitting a reconfigure.
module vticket_scheduler #(
  parameter int VECTOR_TICKET_BITS = 4,
  parameter int MAX_INFLIGHT       = (1 << VECTOR_TICKET_BITS) - 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          valid_i,
  input  logic                          reconfigure_i,
  output logic                          issue_ready_o,
  input  logic                          issued_i,
  input  logic [VECTOR_TICKET_BITS-1:0] issued_ticket_i,
  input  logic                          ex_done_i,
  input  logic [VECTOR_TICKET_BITS-1:0] ex_done_ticket_i,
  input  logic                          mem_done_i,
  input  logic [VECTOR_TICKET_BITS-1:0] mem_done_ticket_i,
  input  logic [VECTOR_TICKET_BITS-1:0] query_ticket_i,
  output logic                          query_pending_o,
  output logic [VECTOR_TICKET_BITS:0]   inflight_cnt_o,
  output logic                          draining_o,
  output logic                          err_o,
  output logic                          is_idle_o
);
  localparam int T = VECTOR_TICKET_BITS;
  localparam int N = 1 << T;
  localparam logic [T:0] MAX_C = (T+1)'(MAX_INFLIGHT);

  typedef enum logic [1:0] {RUN, DRAIN, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d, clr_oh, set_oh, after_clr;
  logic [T:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           set_en, issue_set, ex_hit, mem_hit, same_done;
  logic [1:0]     n_clr;
  logic           e_zero, e_dup, e_ex, e_mem, e_rdy, e_drop;

  assign set_en = issued_i && (state_q == RUN);

  // Ticket 0 is reserved and can never become pending.
  assign clr_oh[0] = 1'b0;
  assign set_oh[0] = 1'b0;
  for (genvar i = 1; i < N; i++) begin : g_bit
    assign clr_oh[i] = (ex_done_i  && (ex_done_ticket_i  == T'(i))) ||
                       (mem_done_i && (mem_done_ticket_i == T'(i)));
    assign set_oh[i] = set_en && (issued_ticket_i == T'(i));
  end

  // Completions apply before issue so a retire-and-reissue leaves the bit set.
  assign after_clr = pend_q & ~clr_oh;
  assign pend_d    = after_clr | set_oh;

  assign ex_hit    = ex_done_i  && pend_q[ex_done_ticket_i];
  assign mem_hit   = mem_done_i && pend_q[mem_done_ticket_i];
  assign same_done = ex_done_i && mem_done_i && (ex_done_ticket_i == mem_done_ticket_i);
  assign n_clr     = 2'(ex_hit) + 2'(mem_hit && !same_done);
  assign issue_set = |(set_oh & ~after_clr);
  assign cnt_d     = cnt_q + (T+1)'(issue_set) - (T+1)'(n_clr);

  assign e_zero = set_en && (issued_ticket_i == '0);
  assign e_dup  = set_en && (issued_ticket_i != '0) && after_clr[issued_ticket_i];
  assign e_ex   = ex_done_i  && !pend_q[ex_done_ticket_i];
  assign e_mem  = mem_done_i && !pend_q[mem_done_ticket_i];
  assign e_rdy  = issued_i && !issue_ready_o;

  always_comb begin
    state_d       = state_q;
    issue_ready_o = 1'b0;
    draining_o    = 1'b0;
    e_drop        = 1'b0;
    case (state_q)
      RUN: begin
        if (valid_i && reconfigure_i) begin
          state_d = (cnt_q == '0) ? GRANT : DRAIN;
        end else begin
          issue_ready_o = (cnt_q < MAX_C);
        end
      end
      DRAIN: begin
        draining_o = 1'b1;
        if (!valid_i) begin
          state_d = RUN;
          e_drop  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        issue_ready_o = 1'b1;
        if (issued_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign err_d = err_q | e_zero | e_dup | e_ex | e_mem | e_rdy | e_drop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RUN;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign query_pending_o = (query_ticket_i != '0) && pend_q[query_ticket_i];
  assign inflight_cnt_o  = cnt_q;
  assign err_o           = err_q;
  assign is_idle_o       = (state_q == RUN) && (cnt_q == '0) && !valid_i;

endmodule

// File: tb/tb_vticket_scheduler.sv
// Scoreboard bench for vticket_scheduler: a set-of-tickets reference model predicts
// every output each cycle; a monitor on the falling edge compares against the DUT.
module tb_vticket_scheduler;
  localparam int T = 4;
  localparam int MAXI = 15;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         valid = 1'b0, reconf = 1'b0, issued = 1'b0, ex_done = 1'b0, mem_done = 1'b0;
  logic [T-1:0] issued_t = '0, ex_t = '0, mem_t = '0, query_t = '0;
  logic         issue_ready, query_pending, draining, err, is_idle;
  logic [T:0]   inflight_cnt;

  vticket_scheduler #(.VECTOR_TICKET_BITS(T), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .reconfigure_i(reconf),
    .issue_ready_o(issue_ready), .issued_i(issued), .issued_ticket_i(issued_t),
    .ex_done_i(ex_done), .ex_done_ticket_i(ex_t), .mem_done_i(mem_done),
    .mem_done_ticket_i(mem_t), .query_ticket_i(query_t), .query_pending_o(query_pending),
    .inflight_cnt_o(inflight_cnt), .draining_o(draining), .err_o(err), .is_idle_o(is_idle)
  );

  always #5 clk = ~clk;

  typedef struct { bit rdy; bit qp; bit drn; bit er; bit idle; int cnt; } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;

  // Reference model: which tickets are outstanding, which phase we are in, sticky error.
  bit pend[16];
  int mode;   // 0 normal issue, 1 waiting for drain, 2 reconfigure admitted
  bit merr;

  function automatic int mcount();
    int c = 0;
    for (int i = 1; i < 16; i++) c += pend[i];
    return c;
  endfunction

  function automatic bit mready(bit v, bit rc);
    if (mode == 0) return (v && rc) ? 1'b0 : (mcount() < MAXI);
    return mode == 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("issue_ready", 32'(issue_ready), 32'(e.rdy));
      chk("query_pending", 32'(query_pending), 32'(e.qp));
      chk("inflight_cnt", 32'(inflight_cnt), 32'(e.cnt));
      chk("draining", 32'(draining), 32'(e.drn));
      chk("err", 32'(err), 32'(e.er));
      chk("is_idle", 32'(is_idle), 32'(e.idle));
    end
  end

  task automatic step(input bit rst_l, input bit v, input bit rc, input bit iss, input int it,
                      input bit exd, input int et, input bit md, input int mt, input int q);
    exp_t e;
    bit rdy;
    int c0;
    @(posedge clk); #1;
    rstn = rst_l; valid = v; reconf = rc; issued = iss; issued_t = T'(it);
    ex_done = exd; ex_t = T'(et); mem_done = md; mem_t = T'(mt); query_t = T'(q);
    if (!rst_l) begin
      for (int i = 0; i < 16; i++) pend[i] = 0;
      mode = 0; merr = 0;
    end
    c0 = mcount();
    rdy = mready(v, rc);
    e.rdy = rdy; e.qp = (q != 0) && pend[q]; e.cnt = c0; e.drn = (mode == 1);
    e.er = merr; e.idle = (mode == 0) && (c0 == 0) && !v;
    sb.push_back(e);
    if (rst_l) begin
      if (exd && !pend[et]) merr = 1;
      if (md && !pend[mt]) merr = 1;
      if (exd) pend[et] = 0;
      if (md) pend[mt] = 0;
      if (iss && !rdy) merr = 1;
      if (iss && mode == 0) begin
        if (it == 0) merr = 1;
        else begin
          if (pend[it]) merr = 1;
          pend[it] = 1;
        end
      end
      case (mode)
        0: if (v && rc) mode = (c0 == 0) ? 2 : 1;
        1: if (!v) begin mode = 0; merr = 1; end
           else if (c0 == 0) mode = 2;
        default: if (iss) mode = 0;
      endcase
    end
  endtask

  task automatic idle(input int q);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, q);
  endtask
  task automatic issue(input int t);
    step(1, 1, 0, 1, t, 0, 0, 0, 0, t);
  endtask
  task automatic rc(input bit iss, input bit exd, input int et, input bit md, input int mt);
    step(1, 1, 1, iss, 0, exd, et, md, mt, 0);
  endtask
  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit hold = 0;
    do_reset();
    // Three issues, then look up a pending ticket and the reserved one.
    issue(1); issue(2); issue(3);
    idle(2); idle(0);
    // Fill to the limit, retire 7 while full, then reissue it.
    for (int t = 4; t <= 15; t++) issue(t);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 7);
    step(1, 1, 0, 0, 0, 1, 7, 0, 0, 7);
    issue(7);
    idle(7);
    // Both completion ports on the same ticket, then a stray completion.
    do_reset();
    for (int t = 1; t <= 5; t++) issue(t);
    step(1, 0, 0, 0, 0, 1, 4, 1, 4, 4);
    step(1, 0, 0, 0, 0, 0, 0, 1, 4, 4);
    idle(0); idle(5);
    // Reconfigure behind two outstanding tickets.
    do_reset();
    issue(1); issue(2);
    rc(0, 0, 0, 0, 0);
    rc(0, 1, 1, 0, 0);
    rc(0, 0, 0, 1, 2);
    rc(0, 0, 0, 0, 0);
    rc(1, 0, 0, 0, 0);
    idle(0);
    // Reconfigure with nothing outstanding, held off downstream for three cycles.
    rc(0, 0, 0, 0, 0);
    rc(0, 0, 0, 0, 0); rc(0, 0, 0, 0, 0); rc(0, 0, 0, 0, 0);
    rc(1, 0, 0, 0, 0);
    idle(0);
    // Reset in the middle of a drain that also flagged an illegal issue.
    for (int t = 1; t <= 6; t++) issue(t);
    rc(0, 0, 0, 0, 0);
    rc(1, 0, 0, 0, 0);
    rc(0, 0, 0, 0, 0);
    do_reset();
    idle(3);
    // Upstream drops valid during a drain.
    issue(1);
    rc(0, 0, 0, 0, 0);
    idle(1); idle(1);
    do_reset();
    // Randomised legal traffic with occasional reconfigures.
    repeat (3000) begin
      int pl[$], fl[$];
      bit v, r, iss, exd, md;
      int it, et, mt, q;
      for (int t = 1; t < 16; t++) if (pend[t]) pl.push_back(t);
      exd = (pl.size() > 0) && ($urandom % 3 == 0);
      md  = (pl.size() > 0) && ($urandom % 3 == 0);
      et  = exd ? pl[$urandom % pl.size()] : 0;
      mt  = md  ? pl[$urandom % pl.size()] : 0;
      q   = $urandom % 16;
      it  = 0;
      if (!hold && mode == 0 && ($urandom % 25 == 0)) hold = 1;
      if (hold) begin
        v = 1; r = 1;
        iss = (mode == 2) && ($urandom % 2 == 0);
        it = $urandom % 16;
        if (iss) hold = 0;
      end else begin
        r = 0;
        for (int t = 1; t < 16; t++)
          if (!pend[t] || (exd && t == et) || (md && t == mt)) fl.push_back(t);
        iss = mready(1, 0) && (fl.size() > 0) && ($urandom % 2 == 0);
        if (iss) it = fl[$urandom % fl.size()];
        v = iss | ($urandom % 2 == 0);
      end
      step(1, v, r, iss, it, exd, et, md, mt, q);
    end
    idle(0); idle(0);
    @(negedge clk); #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
